// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with per-sample debounce and an ack handshake for key events.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned DEBOUNCE_CNT = 3,
   parameter int unsigned REPEAT_DLY   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keyPadIn,
   output logic [3:0] keyPadOut,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ack,
   output logic       key_down
);

   typedef enum logic [1:0] {StScan, StDebounce, StPresent, StRelease} state_e;

   localparam logic [15:0] DwellLast = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  DebLast   = 4'(DEBOUNCE_CNT);

   state_e      state_q, state_d;
   logic [15:0] dwell_q, dwell_d;
   logic [3:0]  match_q, match_d;
   logic [3:0]  row_q, row_d;
   logic [3:0]  cand_col_q, cand_col_d;
   logic [3:0]  cand_code_q, cand_code_d;
   logic        valid_q, valid_d;
   logic [3:0]  code_q, code_d;
   logic        down_q, down_d;

   logic        sample;
   logic        col_ok;
   logic [1:0]  col_idx;
   logic [1:0]  row_idx;
   logic        col_low;
   logic [3:0]  row_next;
   logic [3:0]  match_inc;

`ifdef KEY_REPEAT_EN
   localparam logic [15:0] RepLast = 16'(REPEAT_DLY);
   logic [15:0] rep_q, rep_d;
`else
   logic [15:0] unused_repeat_dly;
   assign unused_repeat_dly = 16'(REPEAT_DLY);
`endif

   always_comb begin
      sample = (dwell_q == DwellLast);
      col_ok  = 1'b1;
      col_idx = 2'd0;
      case (keyPadIn)
         4'b0111: col_idx = 2'd0;
         4'b1011: col_idx = 2'd1;
         4'b1101: col_idx = 2'd2;
         4'b1110: col_idx = 2'd3;
         default: col_ok = 1'b0;
      endcase
      row_idx = 2'd0;
      case (row_q)
         4'b1011: row_idx = 2'd1;
         4'b1101: row_idx = 2'd2;
         4'b1110: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      col_low   = |(~keyPadIn & ~cand_col_q);
      row_next  = {row_q[0], row_q[3:1]};
      match_inc = match_q + 4'd1;
   end

   always_comb begin
      state_d     = state_q;
      dwell_d     = sample ? 16'd0 : dwell_q + 16'd1;
      match_d     = match_q;
      row_d       = row_q;
      cand_col_d  = cand_col_q;
      cand_code_d = cand_code_q;
      valid_d     = valid_q;
      code_d      = code_q;
      down_d      = down_q;
`ifdef KEY_REPEAT_EN
      rep_d       = rep_q;
`endif
      case (state_q)
         StScan: begin
            if (sample) begin
               if (col_ok) begin
                  cand_col_d  = keyPadIn;
                  cand_code_d = {row_idx, col_idx};
                  match_d     = 4'd1;
                  if (DEBOUNCE_CNT == 1) begin
                     state_d = StPresent;
                     valid_d = 1'b1;
                     code_d  = {row_idx, col_idx};
                     down_d  = 1'b1;
                     match_d = 4'd0;
                  end else begin
                     state_d = StDebounce;
                  end
               end else begin
                  row_d = row_next;
               end
            end
         end
         StDebounce: begin
            if (sample) begin
               if (keyPadIn == cand_col_q) begin
                  match_d = match_inc;
                  if (match_inc == DebLast) begin
                     state_d = StPresent;
                     valid_d = 1'b1;
                     code_d  = cand_code_q;
                     down_d  = 1'b1;
                     match_d = 4'd0;
                  end
               end else begin
                  state_d = StScan;
                  row_d   = row_next;
                  match_d = 4'd0;
               end
            end
         end
         StPresent: begin
            // The FSM ignores keyPadIn here; only the held indication tracks it.
            if (sample) down_d = col_low;
            if (key_ack) begin
               state_d = StRelease;
               valid_d = 1'b0;
               match_d = 4'd0;
`ifdef KEY_REPEAT_EN
               rep_d   = 16'd0;
`endif
            end
         end
         default: begin
            if (sample) begin
               down_d = col_low;
               if (keyPadIn == 4'hF) begin
                  match_d = match_inc;
                  if (match_inc == DebLast) begin
                     state_d = StScan;
                     row_d   = row_next;
                     match_d = 4'd0;
                     down_d  = 1'b0;
                  end
               end else begin
                  match_d = 4'd0;
               end
`ifdef KEY_REPEAT_EN
               if (col_low) begin
                  rep_d = rep_q + 16'd1;
                  if (rep_q + 16'd1 == RepLast) begin
                     state_d = StPresent;
                     valid_d = 1'b1;
                     rep_d   = 16'd0;
                  end
               end else begin
                  rep_d = 16'd0;
               end
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StScan;
         dwell_q     <= 16'd0;
         match_q     <= 4'd0;
         row_q       <= 4'b0111;
         cand_col_q  <= 4'hF;
         cand_code_q <= 4'h0;
         valid_q     <= 1'b0;
         code_q      <= 4'h0;
         down_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q       <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         dwell_q     <= dwell_d;
         match_q     <= match_d;
         row_q       <= row_d;
         cand_col_q  <= cand_col_d;
         cand_code_q <= cand_code_d;
         valid_q     <= valid_d;
         code_q      <= code_d;
         down_q      <= down_d;
`ifdef KEY_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign keyPadOut = row_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_down  = down_q;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clk cycles each row is driven (dwell); legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 3: consecutive matching samples required to accept a press or a release; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_DLY, default 8: held-key samples before an auto-repeat event; used only with KEY_REPEAT_EN.
REQ-004 SHALL have these ports, one per line:
  clk  input  1  system clock, all logic on rising edge.
  rst  input  1  synchronous, active-high reset.
  keyPadIn  input  4  keypad columns, active-low; bit3 = col0 ... bit0 = col3.
  keyPadOut  output  4  keypad row drive, active-low one-cold; 4'b0111 = row0 ... 4'b1110 = row3.
  key_valid  output  1  key event available.
  key_code  output  4  event code = {row[1:0], col[1:0]}.
  key_ack  input  1  consumer accepts the event.
  key_down  output  1  accepted key still physically held.

Function
REQ-005 SHALL implement FSM states SCAN, DEBOUNCE, PRESENT, RELEASE.
REQ-006 Dwell counter SHALL count 0..SCAN_DIV-1 in every state; keyPadIn SHALL be sampled only on the cycle the counter equals SCAN_DIV-1.
REQ-007 SCAN: at each sample with no valid column, row SHALL advance 4'b0111 -> 4'b1011 -> 4'b1101 -> 4'b1110 -> 4'b0111 on the next cycle.
REQ-008 Valid column pattern SHALL be exactly one zero bit (4'b0111, 4'b1011, 4'b1101, 4'b1110); any other pattern, including multiple zeros, SHALL be treated as no key.
REQ-009 SCAN with valid column at a sample SHALL freeze the row, latch the candidate code, set the match count to 1, and go to DEBOUNCE; if DEBOUNCE_CNT=1, go directly to PRESENT.
REQ-010 DEBOUNCE: row SHALL stay frozen; a sample equal to the candidate column SHALL increment the match count; on reaching DEBOUNCE_CNT, go to PRESENT.
REQ-011 DEBOUNCE: a non-matching sample SHALL return to SCAN with the row advanced to the next row; no event SHALL be produced.
REQ-012 PRESENT: key_valid SHALL be 1, and key_code SHALL be stable and equal to the latched code.
REQ-013 Transfer SHALL occur on a cycle with key_valid=1 and key_ack=1; the next cycle SHALL have key_valid=0 and state RELEASE.
REQ-014 key_ack while key_valid=0 SHALL be ignored.
REQ-015 PRESENT SHALL ignore keyPadIn; key_valid SHALL remain 1 until acked, even if the key is released.
REQ-016 RELEASE: row SHALL stay frozen; DEBOUNCE_CNT consecutive samples of 4'b1111 SHALL return to SCAN with the row advanced; any other sample SHALL clear the release count.
REQ-017 key_down SHALL be 1 in PRESENT and RELEASE while the most recent sample shows the latched column low, and 0 otherwise.
REQ-018 Press-to-valid latency from first detecting sample SHALL be (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles.
REQ-019 key_code SHALL hold its last value while key_valid=0.

Reset
REQ-020 rst=1 at a rising edge SHALL, at the next cycle, set: keyPadOut=4'b0111, key_valid=0, key_code=4'h0, key_down=0, state=SCAN, and all counters=0.
REQ-021 rst SHALL override key_ack and any state; an unacked event SHALL be discarded.
REQ-022 After reset, the first sample SHALL occur at dwell count SCAN_DIV-1 on row0.

Configuration
REQ-023 Macro KEY_REPEAT_EN defined: in RELEASE, REPEAT_DLY consecutive samples with the latched column low SHALL return to PRESENT with the same key_code; this SHALL repeat every REPEAT_DLY samples while the key is held.
REQ-024 Macro KEY_REPEAT_EN undefined: no repeat; exactly one event SHALL occur per press-release, and REPEAT_DLY SHALL have no effect.

Verification
REQ-025 Defaults, rst then released at cycle 0, row0/col1 held low (keyPadIn=4'b1011 when keyPadOut=4'b0111) -> samples at cycles 3, 7, 11; key_valid=1 with key_code=4'h1 from cycle 12.
REQ-026 Row2/col3 pressed for a single dwell (bounce) -> no key_valid; after that sample, keyPadOut advances to 4'b1110.
REQ-027 Event pending, key_ack held 0 for 50 cycles, key released -> key_valid and key_code=4'hB stay stable; ack -> key_valid=0 next cycle; SCAN resumes after 3 idle samples.
REQ-028 keyPadIn=4'b0011 on any row -> treated as no key; scan continues rotating.
REQ-029 rst asserted in PRESENT -> next cycle key_valid=0, keyPadOut=4'b0111, key_code=0.
REQ-030 KEY_REPEAT_EN defined, key 4'hF held for 40 samples after first ack (acks immediate) -> repeat events every 8 samples; with the macro undefined -> exactly one event.
